// File: rtl/minute_counter.sv
// Minute stage of the clock datapath: two BCD digits 00..59, plus 7-seg drive and carry.
// Latency: one clk from tick_in/inc_pulse/sync_clr to cnt_*, seg_data*, clko.
// Backpressure: none; every tick is consumed on the edge it is sampled (dropped in SET).
//
// Ports
//   clk, rst             clock (posedge) and asynchronous active-high reset
//   tick_in              one-cycle count enable from the seconds stage
//   sync_clr             synchronous clear to 00, beats any increment
//   set_mode, inc_pulse  manual set controls (functional only with MIN_SET_EN)
//   cnt_ones, cnt_tens   registered BCD digits
//   seg_data1, seg_data2 registered 7-seg patterns {a,b,c,d,e,f,g,dp} for ones/tens
//   clko                 one-cycle carry to the hour stage on a tick-driven 59->00 wrap
//   setting              high while in SET (always 0 without MIN_SET_EN)
//
// Build option: define MIN_SET_EN to enable the RUN/SET manual-set FSM.

module minute_counter #(
   parameter logic [3:0] MAX_TENS = 4'd5,
   parameter logic [3:0] MAX_ONES = 4'd9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_in,
   input  logic       sync_clr,
   input  logic       set_mode,
   input  logic       inc_pulse,
   output logic [3:0] cnt_ones,
   output logic [3:0] cnt_tens,
   output logic [7:0] seg_data1,
   output logic [7:0] seg_data2,
   output logic       clko,
   output logic       setting
);

   // Active-high segments, dp always off; anything outside 0..9 blanks the digit.
   function automatic logic [7:0] f_seg(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hFC;
         4'd1:    s = 8'h60;
         4'd2:    s = 8'hDA;
         4'd3:    s = 8'hF2;
         4'd4:    s = 8'h66;
         4'd5:    s = 8'hB6;
         4'd6:    s = 8'hBE;
         4'd7:    s = 8'hE0;
         4'd8:    s = 8'hFE;
         4'd9:    s = 8'hF6;
         default: s = 8'h00;
      endcase
      return s;
   endfunction

   logic [3:0] r_ones;
   logic [3:0] r_tens;
   logic [7:0] r_seg1;
   logic [7:0] r_seg2;
   logic       r_clko;

   logic       w_at_max;
   logic       w_step;    // advance the count this edge
   logic       w_carry;   // this edge's step is a tick-driven wrap
   logic [3:0] w_nxt_ones;
   logic [3:0] w_nxt_tens;

   assign w_at_max = (r_tens == MAX_TENS) && (r_ones == MAX_ONES);

`ifdef MIN_SET_EN
   typedef enum logic {ST_RUN = 1'b0, ST_SET = 1'b1} state_t;

   state_t r_state;
   logic   r_setting;
   logic   w_run_step;
   logic   w_set_step;

   // In SET a tick is simply lost; only inc_pulse moves the count and it never carries,
   // so the hour stage is left alone while the user adjusts minutes.
   assign w_run_step = (r_state == ST_RUN) && tick_in;
   assign w_set_step = (r_state == ST_SET) && inc_pulse;
   assign w_step     = w_run_step || w_set_step;
   assign w_carry    = w_run_step && w_at_max;

   // set_mode is a level: the state simply follows it, one edge late. A tick that
   // arrives with set_mode rising is still counted because r_state is RUN on that edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_RUN;
         r_setting <= 1'b0;
      end else begin
         r_state   <= set_mode ? ST_SET : ST_RUN;
         r_setting <= set_mode;
      end
   end

   assign setting = r_setting;
`else
   logic w_unused_set;

   assign w_unused_set = set_mode ^ inc_pulse;
   assign w_step       = tick_in;
   assign w_carry      = tick_in && w_at_max;
   assign setting      = 1'b0;
`endif

   always_comb begin
      w_nxt_ones = r_ones;
      w_nxt_tens = r_tens;
      if (sync_clr) begin
         w_nxt_ones = 4'd0;
         w_nxt_tens = 4'd0;
      end else if (w_step) begin
         if (w_at_max) begin
            w_nxt_ones = 4'd0;
            w_nxt_tens = 4'd0;
         end else if (r_ones == 4'd9) begin
            w_nxt_ones = 4'd0;
            w_nxt_tens = r_tens + 4'd1;
         end else begin
            w_nxt_ones = r_ones + 4'd1;
         end
      end
   end

   // Segments are encoded from the next-state digits so they update on the same
   // edge as the count and never show a stale pattern.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ones <= 4'd0;
         r_tens <= 4'd0;
         r_seg1 <= 8'hFC;
         r_seg2 <= 8'hFC;
         r_clko <= 1'b0;
      end else begin
         r_ones <= w_nxt_ones;
         r_tens <= w_nxt_tens;
         r_seg1 <= f_seg(w_nxt_ones);
         r_seg2 <= f_seg(w_nxt_tens);
         r_clko <= w_carry && !sync_clr;
      end
   end

   assign cnt_ones  = r_ones;
   assign cnt_tens  = r_tens;
   assign seg_data1 = r_seg1;
   assign seg_data2 = r_seg2;
   assign clko      = r_clko;

endmodule
